// File: rtl/tx_sym_sched.sv
// Transmit symbol scheduler: derives sample/symbol strobes from clk and feeds
// mapped 4-level symbols, or zeros while idle, starved or draining, to the transmit filter.
module tx_sym_sched #(
   parameter int                 CLK_DIV    = 4,
   parameter int                 SPS        = 4,
   parameter int                 FLUSH_SYMS = 77,
   parameter logic signed [17:0] SYMBOL_N2  = -18'sd65535,
   parameter logic signed [17:0] SYMBOL_N1  = -18'sd21845,
   parameter logic signed [17:0] SYMBOL_P1  = 18'sd21845,
   parameter logic signed [17:0] SYMBOL_P2  = 18'sd65535
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               sym_valid,
   input  logic [1:0]         sym_data,
   output logic               sym_ready,
   output logic               sam_clk_en,
   output logic               sym_clk_en,
   output logic signed [17:0] sym_out,
   output logic               busy,
   output logic [15:0]        underrun_cnt
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SMP_W = (SPS > 1) ? $clog2(SPS) : 1;
   localparam int DRN_W = (FLUSH_SYMS > 1) ? $clog2(FLUSH_SYMS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   logic [DIV_W-1:0]    r_div;
   logic [SMP_W-1:0]    r_smp;
   logic [DRN_W-1:0]    r_drain;
   state_t              r_state;
   state_t              w_next_state;
   logic signed [17:0]  r_sym_out;
   logic [15:0]         r_underrun_cnt;
   logic                w_xfer;

   // Gray-coded dibit to 4-level amplitude
   function automatic logic signed [17:0] map_sym(input logic [1:0] d);
      case (d)
         2'b00:   map_sym = SYMBOL_N2;
         2'b01:   map_sym = SYMBOL_N1;
         2'b11:   map_sym = SYMBOL_P1;
         default: map_sym = SYMBOL_P2;
      endcase
   endfunction

   assign sam_clk_en = (r_div == DIV_W'(CLK_DIV - 1));
   assign sym_clk_en = sam_clk_en && (r_smp == SMP_W'(SPS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div <= '0;
         r_smp <= '0;
      end else begin
         r_div <= sam_clk_en ? '0 : r_div + 1'b1;
         if (sam_clk_en)
            r_smp <= sym_clk_en ? '0 : r_smp + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      sym_ready    = 1'b0;
      case (r_state)
         S_IDLE:  if (sym_clk_en && enable)       w_next_state = S_RUN;
         S_RUN: begin
            sym_ready = sym_clk_en && enable;
            if (sym_clk_en && !enable)            w_next_state = S_DRAIN;
         end
         S_DRAIN: if (sym_clk_en && r_drain == '0) w_next_state = S_IDLE;
         default:                                 w_next_state = S_IDLE;
      endcase
   end

   assign w_xfer       = sym_ready && sym_valid;
   assign busy         = (r_state != S_IDLE);
   assign sym_out      = r_sym_out;
   assign underrun_cnt = r_underrun_cnt;

   // Drain counter: loaded on the RUN->DRAIN boundary, leaves DRAIN after reaching 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_drain <= '0;
      else if (sym_clk_en) begin
         if (r_state == S_RUN && !enable)
            r_drain <= DRN_W'(FLUSH_SYMS - 1);
         else if (r_state == S_DRAIN && r_drain != '0)
            r_drain <= r_drain - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_sym_out <= '0;
      else if (sym_clk_en)
         r_sym_out <= w_xfer ? map_sym(sym_data) : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_underrun_cnt <= '0;
      else if (sym_ready && !sym_valid && r_underrun_cnt != 16'hFFFF)
         r_underrun_cnt <= r_underrun_cnt + 16'd1;
   end

endmodule

// File: tb/tb_tx_sym_sched.sv
// Directed bench for tx_sym_sched: vector table per symbol boundary plus
// hand-written sequences for reset timing, drain, saturation and reset aborts.
module tb_tx_sym_sched;

   localparam int                 CLK_DIV = 4;
   localparam int                 SPS     = 4;
   localparam int                 FLUSH   = 77;
   localparam logic signed [17:0] LVL_N2  = -18'sd65535;
   localparam logic signed [17:0] LVL_N1  = -18'sd21845;
   localparam logic signed [17:0] LVL_P1  = 18'sd21845;
   localparam logic signed [17:0] LVL_P2  = 18'sd65535;

   logic               clk;
   logic               reset;
   logic               enable;
   logic               sym_valid;
   logic [1:0]         sym_data;
   logic               sym_ready;
   logic               sam_clk_en;
   logic               sym_clk_en;
   logic signed [17:0] sym_out;
   logic               busy;
   logic [15:0]        underrun_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic               en;
      logic               vld;
      logic [1:0]         dat;
      logic               rdy;
      logic signed [17:0] out;
      logic [15:0]        und;
      logic               bsy;
   } vec_t;

   vec_t tbl[11];

   tx_sym_sched dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .sym_valid    (sym_valid),
      .sym_data     (sym_data),
      .sym_ready    (sym_ready),
      .sam_clk_en   (sam_clk_en),
      .sym_clk_en   (sym_clk_en),
      .sym_out      (sym_out),
      .busy         (busy),
      .underrun_cnt (underrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected test to complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance to the negedge preceding the next symbol-boundary clock edge
   task automatic wait_bnd(input string name);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (sym_clk_en) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s.bnd: got no sym_clk_en in 64 clks, expected one", name);
      end
   endtask

   task automatic do_bnd(input string name, input logic rdy, input logic signed [17:0] out,
                         input logic [15:0] und, input logic bsy);
      wait_bnd(name);
      check({name, ".rdy"}, longint'(sym_ready), longint'(rdy));
      @(posedge clk);
      #1;
      check({name, ".out"}, longint'(sym_out), longint'(out));
      check({name, ".und"}, longint'(underrun_cnt), longint'(und));
      check({name, ".bsy"}, longint'(busy), longint'(bsy));
   endtask

   // Release reset at a negedge and measure strobe timing with enable low
   task automatic release_and_time(input string name);
      int c;
      int first_sam;
      int first_sym;
      int gap_sym;
      int sams;
      bit any_rdy;
      reset     = 1'b0;
      c         = 0;
      first_sam = -1;
      first_sym = -1;
      any_rdy   = 1'b0;
      while (c < 64 && first_sym < 0) begin
         @(negedge clk);
         c++;
         if (sym_ready) any_rdy = 1'b1;
         if (sam_clk_en && first_sam < 0) first_sam = c + 1;
         if (sym_clk_en) first_sym = c + 1;
      end
      check({name, ".first_sam"}, longint'(first_sam), longint'(CLK_DIV));
      check({name, ".first_sym"}, longint'(first_sym), longint'(CLK_DIV * SPS));
      gap_sym = -1;
      sams    = 0;
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         if (sym_ready) any_rdy = 1'b1;
         if (sam_clk_en) sams++;
         if (sym_clk_en) begin
            gap_sym = i;
            break;
         end
      end
      check({name, ".sym_period"}, longint'(gap_sym), longint'(CLK_DIV * SPS));
      check({name, ".sams_per_sym"}, longint'(sams), longint'(SPS));
      check({name, ".no_rdy"}, longint'(any_rdy), 0);
      check({name, ".busy"}, longint'(busy), 0);
      check({name, ".out"}, longint'(sym_out), 0);
      check({name, ".und"}, longint'(underrun_cnt), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 2'b00, 1'b0, 18'sd0,  16'd0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 2'b00, 1'b0, 18'sd0,  16'd0, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 2'b00, 1'b1, LVL_N2,  16'd0, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 2'b01, 1'b1, LVL_N1,  16'd0, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 2'b11, 1'b1, LVL_P1,  16'd0, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 2'b10, 1'b1, LVL_P2,  16'd0, 1'b1};
      tbl[6]  = '{1'b1, 1'b0, 2'b11, 1'b1, 18'sd0,  16'd1, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 2'b01, 1'b1, 18'sd0,  16'd2, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 2'b00, 1'b1, 18'sd0,  16'd3, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 2'b10, 1'b1, LVL_P2,  16'd3, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 2'b11, 1'b0, 18'sd0,  16'd3, 1'b1};

      reset     = 1'b1;
      enable    = 1'b0;
      sym_valid = 1'b0;
      sym_data  = 2'b00;
      repeat (3) @(negedge clk);
      check("rst.sam", longint'(sam_clk_en), 0);
      check("rst.sym", longint'(sym_clk_en), 0);
      check("rst.rdy", longint'(sym_ready), 0);
      check("rst.out", longint'(sym_out), 0);
      check("rst.busy", longint'(busy), 0);
      check("rst.und", longint'(underrun_cnt), 0);
      release_and_time("rel1");

      for (int i = 0; i < 11; i++) begin
         enable    = tbl[i].en;
         sym_valid = tbl[i].vld;
         sym_data  = tbl[i].dat;
         do_bnd($sformatf("row%0d", i), tbl[i].rdy, tbl[i].out, tbl[i].und, tbl[i].bsy);
         sym_valid = ~tbl[i].vld;
         sym_data  = ~tbl[i].dat;
         repeat (5) @(negedge clk);
         check($sformatf("row%0d.hold", i), longint'(sym_out), longint'(tbl[i].out));
      end

      // Drain: 77 boundaries in DRAIN, enable returns partway and must be ignored
      sym_valid = 1'b1;
      sym_data  = 2'b10;
      for (int k = 1; k <= FLUSH; k++) begin
         enable = (k >= 30);
         do_bnd($sformatf("drain%0d", k), 1'b0, 18'sd0, 16'd3, (k < FLUSH));
      end
      enable = 1'b0;
      do_bnd("post_drain", 1'b0, 18'sd0, 16'd3, 1'b0);

      // Underrun saturation, preloaded near the top of the range
      enable    = 1'b1;
      sym_valid = 1'b0;
      do_bnd("sat.start", 1'b0, 18'sd0, 16'd3, 1'b1);
      do_bnd("sat.miss0", 1'b1, 18'sd0, 16'd4, 1'b1);
      @(negedge clk);
      force dut.r_underrun_cnt = 16'hFFFD;
      @(negedge clk);
      release dut.r_underrun_cnt;
      do_bnd("sat.miss1", 1'b1, 18'sd0, 16'hFFFE, 1'b1);
      do_bnd("sat.miss2", 1'b1, 18'sd0, 16'hFFFF, 1'b1);
      do_bnd("sat.miss3", 1'b1, 18'sd0, 16'hFFFF, 1'b1);
      enable = 1'b0;
      do_bnd("sat.stop", 1'b0, 18'sd0, 16'hFFFF, 1'b1);
      do_bnd("sat.drain1", 1'b0, 18'sd0, 16'hFFFF, 1'b1);
      do_bnd("sat.drain2", 1'b0, 18'sd0, 16'hFFFF, 1'b1);

      // Reset pulse mid-DRAIN
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rstd.busy", longint'(busy), 0);
      check("rstd.und", longint'(underrun_cnt), 0);
      check("rstd.out", longint'(sym_out), 0);
      check("rstd.rdy", longint'(sym_ready), 0);
      check("rstd.sam", longint'(sam_clk_en), 0);
      check("rstd.sym", longint'(sym_clk_en), 0);
      repeat (2) @(negedge clk);
      release_and_time("rel2");

      // Reset pulse mid-RUN while a nonzero level is held
      enable    = 1'b1;
      sym_valid = 1'b1;
      sym_data  = 2'b10;
      do_bnd("rr.start", 1'b0, 18'sd0, 16'd0, 1'b1);
      do_bnd("rr.sym", 1'b1, LVL_P2, 16'd0, 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rstr.out", longint'(sym_out), 0);
      check("rstr.busy", longint'(busy), 0);
      check("rstr.rdy", longint'(sym_ready), 0);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      release_and_time("rel3");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tx_sym_sched.md
TX_SYM_SCHED -- requirements
Module: tx_sym_sched

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per output sample (>=2).
REQ-002 SHALL have parameter SPS, default 4: samples per symbol; fixed to match the 4x polyphase transmit filter.
REQ-003 SHALL have parameter FLUSH_SYMS, default 77: zero symbols emitted on drain, equal to filter symbol depth.
REQ-004 SHALL have port clk, input, 1: sole clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: level; 1 = transmit, 0 = stop after drain.
REQ-007 SHALL have port sym_valid, input, 1: source holds a valid symbol.
REQ-008 SHALL have port sym_data, input, 2: Gray-coded symbol bits.
REQ-009 SHALL have port sym_ready, output, 1: symbol accepted this cycle when sym_valid=1.
REQ-010 SHALL have port sam_clk_en, output, 1: one-clk sample strobe to the filter.
REQ-011 SHALL have port sym_clk_en, output, 1: one-clk symbol strobe to the filter.
REQ-012 SHALL have port sym_out, output, 18 signed: level to the filter input.
REQ-013 SHALL have port busy, output, 1: state != IDLE.
REQ-014 SHALL have port underrun_cnt, output, 16: saturating count of missed symbols.

Function
REQ-015 SHALL run a free divider div 0..CLK_DIV-1 in every state; sam_clk_en = (div==CLK_DIV-1).
REQ-016 SHALL run sample counter smp 0..SPS-1, advancing only on sam_clk_en, wrapping SPS-1->0.
REQ-017 SHALL assert sym_clk_en = sam_clk_en && smp==SPS-1, so sym_clk_en always coincides with a sam_clk_en; period CLK_DIV*SPS clks.
REQ-018 SHALL implement states IDLE, RUN, DRAIN; all transitions only on sym_clk_en cycles.
REQ-019 IDLE: enable=1 at sym_clk_en -> RUN; sym_ready not asserted on that boundary.
REQ-020 RUN: enable=0 at sym_clk_en -> DRAIN, drain counter loaded to FLUSH_SYMS-1, sym_ready not asserted, zero symbol emitted.
REQ-021 DRAIN: enable ignored; each sym_clk_en emits zero and decrements counter; at counter 0 on a boundary -> IDLE.
REQ-022 SHALL drive sym_ready combinationally = sym_clk_en && state==RUN && enable; transfer = sym_ready && sym_valid.
REQ-023 On transfer, sym_out SHALL register mapped level: 00->SYMBOL_N2, 01->SYMBOL_N1, 11->SYMBOL_P1, 10->SYMBOL_P2 (codebase defines).
REQ-024 On any sym_clk_en without transfer, sym_out SHALL register 0; sym_out holds between boundaries.
REQ-025 sym_valid=0 at a RUN boundary with sym_ready=1 SHALL emit 0 and increment underrun_cnt, saturating at 16'hFFFF.
REQ-026 underrun_cnt SHALL clear only on reset; never counts in IDLE or DRAIN.
REQ-027 Latency: symbol accepted at boundary k appears on sym_out one clk later, consumed by filter at boundary k+1.
REQ-028 sym_valid/sym_data between boundaries SHALL be ignored; no buffering.

Reset
REQ-029 On reset: div=0, smp=0, state=IDLE, drain counter=0, sym_out=0, underrun_cnt=0, sam_clk_en=0, sym_clk_en=0, sym_ready=0, busy=0.
REQ-030 Reset mid-RUN or mid-DRAIN SHALL abort immediately to reset values; no drain on reset.
REQ-031 First sam_clk_en after reset release SHALL occur CLK_DIV clks after release; first sym_clk_en CLK_DIV*SPS clks after.

Verification
REQ-032 Defaults, enable=0 after reset -> sam_clk_en every 4 clks, sym_clk_en every 16 clks, sym_ready never high, sym_out=0, busy=0.
REQ-033 enable=1, sym_valid=1, data 00,01,11,10 -> sym_out N2,N1,P1,P2 on successive boundaries starting second boundary after enable; underrun_cnt=0.
REQ-034 RUN with sym_valid=0 for 3 boundaries -> sym_out=0 on those, underrun_cnt=3; force 70000 misses -> holds 65535.
REQ-035 enable drops in RUN -> exactly 77 zero symbols, busy falls at 77th boundary, no sym_ready pulses during DRAIN even if enable returns.
REQ-036 Reset pulse during DRAIN -> all outputs reset value same cycle; after release busy=0, counters restart from 0.
